// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR pattern test sequencer: FSM states and
// default geometry/timing parameters.
package ddr_test_pkg;

    localparam int DDR_ADR_W      = 25;
    localparam int DDR_DATA_W     = 256;
    localparam int DDR_GAP_CYCLES = 4;
    localparam int DDR_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_GAP  = 3'd2,
        RD_REQ  = 3'd3,
        RD_CAPT = 3'd4,
        RD_GAP  = 3'd5,
        FIN     = 3'd6
    } ddr_state_t;

endpackage

// File: rtl/ddr_pattern_gen.sv
// Combinational test pattern: 32-bit lane i of the word at address a is
// seed + a + i (mod 2^32), address zero-extended.
module ddr_pattern_gen
    import ddr_test_pkg::*;
#(
    parameter int ADR_W  = DDR_ADR_W,
    parameter int DATA_W = DDR_DATA_W
) (
    input  logic [31:0]       seed_i,
    input  logic [ADR_W-1:0]  adr_i,
    output logic [DATA_W-1:0] pat_o
);

    localparam int LANES = DATA_W / 32;

    logic [31:0] base;

    assign base = seed_i + 32'(adr_i);

    // One adder per lane, offset by the lane index.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign pat_o[l*32 +: 32] = base + 32'(l);
    end

endmodule

// File: rtl/ddr_pattern_seq.sv
// DDR memory test sequencer: writes P(a) over [adr_first..adr_last]
// (wrapping modulo 2^ADR_W), reads the range back, counts mismatches.
// Every request is followed by a fixed low gap; requests time out.
module ddr_pattern_seq
    import ddr_test_pkg::*;
#(
    parameter int ADR_W      = DDR_ADR_W,
    parameter int DATA_W     = DDR_DATA_W,
    parameter int GAP_CYCLES = DDR_GAP_CYCLES,
    parameter int TIMEOUT    = DDR_TIMEOUT
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  start,
    input  logic [ADR_W-1:0]      adr_first,
    input  logic [ADR_W-1:0]      adr_last,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_cnt,
    output logic [ADR_W-1:0]      first_err_adr,
    output logic                  wr_rq,
    output logic                  rd_rq,
    output logic [ADR_W-1:0]      wr_adr,
    output logic [ADR_W-1:0]      rd_adr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   byte_enable,
    input  logic                  action_done,
    input  logic [DATA_W-1:0]     rd_data
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    ddr_state_t        state_q, state_d;
    logic [ADR_W-1:0]  cur_adr_q, cur_adr_d;
    logic [ADR_W-1:0]  first_q, first_d;
    logic [ADR_W-1:0]  last_q, last_d;
    logic [31:0]       seed_q, seed_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              start_acc;

    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [ADR_W-1:0]  first_err_q, first_err_d;
    logic              timeout_q, timeout_d;
    logic              pass_q, pass_d;

    logic              wr_rq_q, rd_rq_q, done_q, busy_q;
    logic [ADR_W-1:0]  wr_adr_q, rd_adr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic [DATA_W-1:0] pat;
    logic              mismatch;

    // The generator looks at next-state address/seed: on entry to WR_REQ that
    // is the word about to be written, and in RD_CAPT it equals cur_adr_q.
    ddr_pattern_gen #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) u_pat (
        .seed_i (seed_d),
        .adr_i  (cur_adr_d),
        .pat_o  (pat)
    );

    assign mismatch = (rd_data != pat);

    // Sequencing FSM: next state, address walk, wait and gap counters.
    always_comb begin
        state_d   = state_q;
        cur_adr_d = cur_adr_q;
        first_d   = first_q;
        last_d    = last_q;
        seed_d    = seed_q;
        wait_d    = '0;
        gap_d     = '0;
        timeout_d = timeout_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    first_d   = adr_first;
                    last_d    = adr_last;
                    seed_d    = seed;
                    cur_adr_d = adr_first;
                    timeout_d = 1'b0;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                // action_done takes priority over an expiring wait counter
                if (action_done) begin
                    state_d = (state_q == WR_REQ) ? WR_GAP : RD_CAPT;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WR_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (cur_adr_q == last_q) begin
                        cur_adr_d = first_q;
                        state_d   = RD_REQ;
                    end else begin
                        cur_adr_d = cur_adr_q + 1'b1;
                        state_d   = WR_REQ;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            RD_CAPT: begin
                state_d = RD_GAP;
            end
            RD_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (cur_adr_q == last_q) begin
                        state_d = FIN;
                    end else begin
                        cur_adr_d = cur_adr_q + 1'b1;
                        state_d   = RD_REQ;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Run results: error count/first address on compare, pass at run end.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        if (start_acc) begin
            err_cnt_d   = '0;
            first_err_d = '0;
            pass_d      = 1'b0;
        end else if (state_q == RD_CAPT && mismatch) begin
            if (err_cnt_q == 16'h0000) begin
                first_err_d = cur_adr_q;
            end
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
        if (state_d == FIN) begin
            pass_d = (err_cnt_d == 16'h0000) && !timeout_d;
        end
    end

    // State, results and registered request/status outputs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            cur_adr_q   <= '0;
            first_q     <= '0;
            last_q      <= '0;
            seed_q      <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            wr_rq_q     <= 1'b0;
            rd_rq_q     <= 1'b0;
            wr_adr_q    <= '0;
            rd_adr_q    <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_adr_q   <= cur_adr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            seed_q      <= seed_d;
            wait_q      <= wait_d;
            gap_q       <= gap_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            // Request outputs follow the state being entered, so they are
            // glitch-free and constant for the whole request.
            wr_rq_q     <= (state_d == WR_REQ);
            rd_rq_q     <= (state_d == RD_REQ);
            wr_adr_q    <= (state_d == WR_REQ) ? cur_adr_d : '0;
            rd_adr_q    <= (state_d == RD_REQ) ? cur_adr_d : '0;
            wr_data_q   <= (state_d == WR_REQ) ? pat : '0;
            done_q      <= (state_d == FIN);
            busy_q      <= (state_d != IDLE) && (state_d != FIN);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_adr = first_err_q;
    assign wr_rq         = wr_rq_q;
    assign rd_rq         = rd_rq_q;
    assign wr_adr        = wr_adr_q;
    assign rd_adr        = rd_adr_q;
    assign wr_data       = wr_data_q;
    assign byte_enable   = '1;

endmodule
